// File: rtl/set_job_host_if.sv
// Job/result stream bundle for set_job_host. slave = host side, master = upstream/downstream side.
// Handshake: a beat moves on a rising clk edge where valid=1 and ready=1; valid never waits on ready.
interface set_job_host_if #(
  parameter int JOB_W = 26,
  parameter int RES_W = 8
);
  logic             job_valid_i;
  logic             job_ready_o;
  logic [JOB_W-1:0] job_data_i;
  logic             res_valid_o;
  logic             res_ready_i;
  logic [RES_W:0]   res_data_o;

  modport slave (
    input  job_valid_i,
    input  job_data_i,
    input  res_ready_i,
    output job_ready_o,
    output res_valid_o,
    output res_data_o
  );

  modport master (
    output job_valid_i,
    output job_data_i,
    output res_ready_i,
    input  job_ready_o,
    input  res_valid_o,
    input  res_data_o
  );
endinterface

// File: rtl/set_job_host.sv
// Initiator for the SET engine start/busy/valid protocol: job FIFO -> one job in flight -> result FIFO.
// Optional watchdog enabled by defining SET_HOST_TIMEOUT_EN.
module set_job_host #(
  parameter int JOB_W       = 26,
  parameter int RES_W       = 8,
  parameter int DEPTH       = 4,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  set_job_host_if.slave    bus,
  output logic             en_o,
  output logic [15:0]      central_o,
  output logic [7:0]       radius_o,
  output logic [1:0]       mode_o,
  input  logic             busy_i,
  input  logic             valid_i,
  input  logic [RES_W-1:0] candidate_i,
  output logic [15:0]      jobs_done_o,
  output logic [2:0]       state_o
);
  localparam int          AW       = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] ISSUE     = 3'd1;
  localparam logic [2:0] WAIT_BUSY = 3'd2;
  localparam logic [2:0] WAIT_RES  = 3'd3;
  localparam logic [2:0] WAIT_IDLE = 3'd4;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("set_job_host: DEPTH must be a power of 2 and >= 2");
  end
  if (TIMEOUT_CYC < 2) begin : g_bad_timeout
    $error("set_job_host: TIMEOUT_CYC must be >= 2");
  end

  logic [2:0] state_q, state_d;
  logic       load_desc;
  logic       res_push;
  logic [RES_W:0] res_word;
  logic       tmo_hit;

  // ---------------- job FIFO ----------------
  logic [JOB_W-1:0] job_mem [DEPTH];
  logic [AW-1:0]    job_wr, job_rd;
  logic [AW:0]      job_cnt;
  logic             job_push, job_pop;
  logic [JOB_W-1:0] job_head;

  assign bus.job_ready_o = (job_cnt != FULL_CNT);
  assign job_push        = bus.job_valid_i & bus.job_ready_o;
  assign job_pop         = (state_q == ISSUE);
  assign job_head        = job_mem[job_rd];

  always_ff @(posedge clk_i) begin
    if (job_push) job_mem[job_wr] <= bus.job_data_i;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      job_wr  <= '0;
      job_rd  <= '0;
      job_cnt <= '0;
    end else begin
      if (job_push) job_wr <= job_wr + 1'b1;
      if (job_pop)  job_rd <= job_rd + 1'b1;
      case ({job_push, job_pop})
        2'b10:   job_cnt <= job_cnt + 1'b1;
        2'b01:   job_cnt <= job_cnt - 1'b1;
        default: job_cnt <= job_cnt;
      endcase
    end
  end

  // ---------------- result FIFO (first-word-fall-through) ----------------
  logic [RES_W:0] res_mem [DEPTH];
  logic [AW-1:0]  res_wr, res_rd;
  logic [AW:0]    res_cnt;
  logic           res_pop;

  assign bus.res_valid_o = (res_cnt != '0);
  assign bus.res_data_o  = res_mem[res_rd];
  assign res_pop         = bus.res_valid_o & bus.res_ready_i;

  always_ff @(posedge clk_i) begin
    if (res_push) res_mem[res_wr] <= res_word;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      res_wr  <= '0;
      res_rd  <= '0;
      res_cnt <= '0;
    end else begin
      if (res_push) res_wr <= res_wr + 1'b1;
      if (res_pop)  res_rd <= res_rd + 1'b1;
      case ({res_push, res_pop})
        2'b10:   res_cnt <= res_cnt + 1'b1;
        2'b01:   res_cnt <= res_cnt - 1'b1;
        default: res_cnt <= res_cnt;
      endcase
    end
  end

  // ---------------- watchdog ----------------
`ifdef SET_HOST_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC);
  logic [TW-1:0] tmo_cnt;

  always_ff @(posedge clk_i) begin
    if (!rst_ni)                                         tmo_cnt <= '0;
    else if (state_q == ISSUE)                           tmo_cnt <= '0;
    else if (state_q == WAIT_BUSY || state_q == WAIT_RES) tmo_cnt <= tmo_cnt + 1'b1;
  end

  // Fires on the TIMEOUT_CYC-th cycle spent waiting on the engine.
  assign tmo_hit = (state_q == WAIT_BUSY || state_q == WAIT_RES) &&
                   (tmo_cnt == TW'(TIMEOUT_CYC - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  // ---------------- control FSM ----------------
  always_comb begin
    state_d   = state_q;
    load_desc = 1'b0;
    res_push  = 1'b0;
    res_word  = {1'b0, candidate_i};
    case (state_q)
      IDLE: begin
        // Launch only when a result slot is free, so the in-flight job can always retire.
        if (job_cnt != '0 && !busy_i && res_cnt != FULL_CNT) begin
          state_d   = ISSUE;
          load_desc = 1'b1;
        end
      end
      ISSUE: state_d = WAIT_BUSY;
      WAIT_BUSY: begin
        if (tmo_hit) begin
          res_push = 1'b1;
          res_word = {1'b1, {RES_W{1'b0}}};
          state_d  = WAIT_IDLE;
        end else if (busy_i) begin
          state_d = WAIT_RES;
        end
      end
      WAIT_RES: begin
        if (valid_i) begin
          res_push = 1'b1;
          state_d  = WAIT_IDLE;
        end else if (tmo_hit) begin
          res_push = 1'b1;
          res_word = {1'b1, {RES_W{1'b0}}};
          state_d  = WAIT_IDLE;
        end
      end
      WAIT_IDLE: if (!busy_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      central_o   <= '0;
      radius_o    <= '0;
      mode_o      <= '0;
      jobs_done_o <= '0;
    end else begin
      state_q <= state_d;
      // Descriptor is loaded on entry to ISSUE so it is already valid while en_o is high.
      if (load_desc) {mode_o, radius_o, central_o} <= job_head[25:0];
      if (res_push) jobs_done_o <= jobs_done_o + 16'd1;
    end
  end

  assign en_o    = (state_q == ISSUE);
  assign state_o = state_q;
endmodule
